// File: rtl/fxp32_pkg.sv
// Shared definitions for the Q16.16 fixed-point MAC datapath and its sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Exports FXP_DATA_W, FRAC_W and the dot-product controller state encoding.
package fxp32_pkg;

   // Operand/result width used by fxp32_mac and its sequencer.
   localparam int FXP_DATA_W = 32;

   // Q16.16: number of fractional bits, shared with the MAC and the benches.
   localparam int FRAC_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } dot_state_t;

endpackage

// File: rtl/fxp_cnt.sv
// Small up/down counter with load and clear.
// Latency: q updates one cycle after a control input.
// Backpressure: none. Ports: ld/ld_val, clr, inc, dec (priority in that order); q is the count.
module fxp_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (ld) begin
         q <= ld_val;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= q + W'(1);
      end else if (dec) begin
         q <= q - W'(1);
      end
   end

endmodule

// File: rtl/fxp32_dot_ctrl.sv
// Sequencer that drives fxp32_mac through one dot product and returns mac_c as the result.
// Latency: 1 (clear) + len (one pair per cycle) + MAC_LAT+1 (drain) cycles from start to res_valid.
// Backpressure: s_ready only in RUN; result held on res_valid until res_ready. Optional macro FXP32_DOT_TIMEOUT_EN adds err.
//
// Ports: start/len command; s_valid/s_ready/s_a/s_b operand stream; mac_prstn/mac_acc/mac_a/mac_b to the
// MAC and mac_c from it; res_valid/res_ready/res_data result; busy high outside IDLE; err (timeout only).
module fxp32_dot_ctrl
   import fxp32_pkg::*;
#(
   parameter int DATA_W  = FXP_DATA_W,
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_a,
   input  logic [DATA_W-1:0] s_b,
   output logic              mac_prstn,
   output logic              mac_acc,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   input  logic [DATA_W-1:0] mac_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              busy
`ifdef FXP32_DOT_TIMEOUT_EN
   ,
   output logic              err
`endif
);

   if (MAC_LAT < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("fxp32_dot_ctrl: MAC_LAT and TIMEOUT must both be >= 1");
   end

   localparam int DR_W = $clog2(MAC_LAT + 1) + 1;

   dot_state_t        state, state_nxt;
   logic              accept;
   logic              last_pair;
   logic              drain_done;
   logic              to_hit;
   logic [LEN_W-1:0]  rem;
   logic [DR_W-1:0]   drain_cnt;

   logic              prstn_nxt, acc_nxt, s_ready_nxt, res_valid_nxt, busy_nxt;
   logic [DATA_W-1:0] a_nxt, b_nxt, res_nxt;

   // s_ready is registered and only high in RUN, so accept implies RUN.
   assign accept     = s_valid & s_ready;
   assign last_pair  = accept && (rem == LEN_W'(1));
   assign drain_done = (drain_cnt == DR_W'(MAC_LAT));

   fxp_cnt #(.W(LEN_W)) u_rem (
      .clk    (clk),
      .rst    (rst),
      .clr    (1'b0),
      .ld     ((state == ST_IDLE) && start),
      .ld_val (len),
      .inc    (1'b0),
      .dec    (accept),
      .q      (rem)
   );

   // Counts cycles spent in DRAIN; zero on entry.
   fxp_cnt #(.W(DR_W)) u_drain (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != ST_DRAIN),
      .ld     (1'b0),
      .ld_val ('0),
      .inc    (state == ST_DRAIN),
      .dec    (1'b0),
      .q      (drain_cnt)
   );

`ifdef FXP32_DOT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1) + 1;

   logic [TO_W-1:0] idle_cnt;
   logic            err_nxt;

   // Idle-input cycles in RUN; any accepted pair restarts the count.
   fxp_cnt #(.W(TO_W)) u_idle (
      .clk    (clk),
      .rst    (rst),
      .clr    ((state != ST_RUN) || accept),
      .ld     (1'b0),
      .ld_val ('0),
      .inc    ((state == ST_RUN) && !accept),
      .dec    (1'b0),
      .q      (idle_cnt)
   );

   // Fires on the TIMEOUT-th consecutive cycle without an accept.
   assign to_hit = (state == ST_RUN) && !accept && (idle_cnt == TO_W'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mac_prstn <= 1'b0;
         mac_acc   <= 1'b0;
         mac_a     <= '0;
         mac_b     <= '0;
         s_ready   <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
`ifdef FXP32_DOT_TIMEOUT_EN
         err       <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         mac_prstn <= prstn_nxt;
         mac_acc   <= acc_nxt;
         mac_a     <= a_nxt;
         mac_b     <= b_nxt;
         s_ready   <= s_ready_nxt;
         res_valid <= res_valid_nxt;
         res_data  <= res_nxt;
         busy      <= busy_nxt;
`ifdef FXP32_DOT_TIMEOUT_EN
         err       <= err_nxt;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = (len != '0) ? ST_CLEAR : ST_DONE;
         ST_CLEAR: state_nxt = ST_RUN;
         ST_RUN: begin
            if (last_pair)   state_nxt = ST_DRAIN;
            else if (to_hit) state_nxt = ST_DONE;
         end
         ST_DRAIN: if (drain_done) state_nxt = ST_DONE;
         // res_valid is always high in DONE, so res_ready alone completes the handshake.
         ST_DONE:  if (res_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: values the output registers take on the next edge.
   always_comb begin
      prstn_nxt     = (state_nxt != ST_CLEAR);
      acc_nxt       = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      s_ready_nxt   = (state_nxt == ST_RUN);
      res_valid_nxt = (state_nxt == ST_DONE);
      busy_nxt      = (state_nxt != ST_IDLE);
      // Zero operands whenever no pair is taken, so accumulating stays harmless.
      a_nxt         = accept ? s_a : '0;
      b_nxt         = accept ? s_b : '0;
      res_nxt       = res_data;
      // Only a normal drain carries a MAC result; len==0 and timeout report zero.
      if ((state != ST_DONE) && (state_nxt == ST_DONE)) begin
         res_nxt = (state == ST_DRAIN) ? mac_c : '0;
      end
`ifdef FXP32_DOT_TIMEOUT_EN
      err_nxt = err;
      if (to_hit) begin
         err_nxt = 1'b1;
      end else if ((state == ST_DONE) && res_ready) begin
         err_nxt = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_fxp32_dot_ctrl.sv
// Scoreboard bench for fxp32_dot_ctrl driving a behavioural Q16.16 MAC model.
// Latency: expected results are queued at start and checked by a monitor on each result handshake.
// Backpressure: bench exercises s_valid gaps and held-low res_ready. Define FXP32_DOT_TIMEOUT_EN for the err case.
module tb_fxp32_dot_ctrl;
   import fxp32_pkg::*;

   localparam int DATA_W  = 32;
   localparam int LEN_W   = 8;
   localparam int MAC_LAT = 2;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_a = '0;
   logic [DATA_W-1:0] s_b = '0;
   logic              mac_prstn, mac_acc;
   logic [DATA_W-1:0] mac_a, mac_b, mac_c;
   logic              res_valid;
   logic              res_ready = 1'b1;
   logic [DATA_W-1:0] res_data;
   logic              busy;
`ifdef FXP32_DOT_TIMEOUT_EN
   logic              err;
`endif

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   acc_cyc = 0;
   logic prstn_low_seen = 1'b0;

   fxp32_dot_ctrl #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W),
      .MAC_LAT(MAC_LAT),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_a      (s_a),
      .s_b      (s_b),
      .mac_prstn(mac_prstn),
      .mac_acc  (mac_acc),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .mac_c    (mac_c),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .busy     (busy)
`ifdef FXP32_DOT_TIMEOUT_EN
      ,
      .err      (err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Q16.16 multiply: signed 64-bit product, arithmetic shift by FRAC_W, 32-bit wrap.
   function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return p[FRAC_W +: 32];
   endfunction

   // MAC model with two register stages (MAC_LAT = 2): accumulator, then output register.
   logic [31:0] m_acc = '0;
   logic [31:0] m_d1 = '0;
   always @(posedge clk) begin
      if (!mac_prstn)  m_acc <= '0;
      else if (mac_acc) m_acc <= m_acc + qmul(mac_a, mac_b);
      else             m_acc <= qmul(mac_a, mac_b);
      m_d1 <= m_acc;
   end
   assign mac_c = m_d1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every result handshake.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %h, expected no result", res_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
`ifdef FXP32_DOT_TIMEOUT_EN
            check("res_err", {31'd0, err}, {31'd0, e.err});
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && !mac_prstn) prstn_low_seen = 1'b1;
   end

   task automatic do_start(input logic [LEN_W-1:0] l, input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      e.data = exp_data;
      e.err  = exp_err;
      exp_q.push_back(e);
      start = 1'b1;
      len   = l;
      @(posedge clk); #1;
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         n++;
         if (n > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: got no s_ready in 200 cycles, required s_ready");
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
   endtask

   task automatic wait_valid();
      int n = 0;
      forever begin
         @(negedge clk);
         if (res_valid) break;
         n++;
         if (n > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_valid_timeout: got no res_valid in 200 cycles, required res_valid");
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_prstn", {31'd0, mac_prstn}, 32'd0);
      check("rst_acc", {31'd0, mac_acc}, 32'd0);
      check("rst_mac_a", mac_a, 32'd0);
      check("rst_mac_b", mac_b, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_prstn", {31'd0, mac_prstn}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Test 1: len=2 back-to-back, 1*2 + 3*4 = 14.0
      do_start(8'd2, 32'h000E_0000, 1'b0);
      check("t1_busy", {31'd0, busy}, 32'd1);
      send_pair(32'h0001_0000, 32'h0002_0000);
      send_pair(32'h0003_0000, 32'h0004_0000);
      wait_valid();
      check("t1_latency", cyc - start_cyc, 32'(1 + 2 + MAC_LAT + 1));
      @(posedge clk); #1;
      check("t1_idle", {31'd0, busy}, 32'd0);

      // Test 2: len=3 with 2-cycle gaps, 3 * (0.5*2.0) = 3.0
      do_start(8'd3, 32'h0003_0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         send_pair(32'h0000_8000, 32'h0002_0000);
         check($sformatf("t2_s_ready_%0d", i), {31'd0, s_ready}, (i < 2) ? 32'd1 : 32'd0);
         if (i < 2) begin
            repeat (2) @(posedge clk);
            #1;
         end
      end
      wait_valid();
      @(posedge clk); #1;

      // Test 3: len=0 finishes next cycle with zero and no clear pulse
      prstn_low_seen = 1'b0;
      do_start(8'd0, 32'h0000_0000, 1'b0);
      check("t3_res_valid", {31'd0, res_valid}, 32'd1);
      check("t3_acc", {31'd0, mac_acc}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t3_prstn_never_low", {31'd0, prstn_low_seen}, 32'd0);
      check("t3_idle", {31'd0, busy}, 32'd0);

      // Test 4: result held 10 cycles under res_ready low; start during DONE ignored
      res_ready = 1'b0;
      do_start(8'd1, 32'h0006_0000, 1'b0);
      send_pair(32'h0002_0000, 32'h0003_0000);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         start = (i == 3);
         len   = 8'd5;
      end
      start = 1'b0;
      check("t4_hold_data", res_data, 32'h0006_0000);
      check("t4_hold_valid", {31'd0, res_valid}, 32'd1);
      check("t4_no_restart", {31'd0, s_ready}, 32'd0);
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_valid_drop", {31'd0, res_valid}, 32'd0);
      check("t4_idle", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_still_idle", {31'd0, busy}, 32'd0);

      // Test 5: reset after 1 of 4 pairs aborts; next run has no residue
      do_start(8'd4, 32'h0004_0000, 1'b0);
      send_pair(32'h0001_0000, 32'h0001_0000);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_s_ready", {31'd0, s_ready}, 32'd0);
      check("t5_prstn", {31'd0, mac_prstn}, 32'd0);
      check("t5_acc", {31'd0, mac_acc}, 32'd0);
      check("t5_mac_a", mac_a, 32'd0);
      check("t5_mac_b", mac_b, 32'd0);
      check("t5_res_data", res_data, 32'd0);
      check("t5_res_valid", {31'd0, res_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_start(8'd1, 32'hFFFF_0000, 1'b0);
      send_pair(32'hFFFF_0000, 32'h0001_0000);
      wait_valid();
      @(posedge clk); #1;

`ifdef FXP32_DOT_TIMEOUT_EN
      // Test 6: one of two pairs, then TIMEOUT idle cycles -> err with zero result
      do_start(8'd2, 32'h0000_0000, 1'b1);
      send_pair(32'h0001_0000, 32'h0001_0000);
      acc_cyc = cyc;
      wait_valid();
      check("t6_timeout_cycles", cyc - acc_cyc, 32'(TIMEOUT));
      check("t6_err", {31'd0, err}, 32'd1);
      @(posedge clk); #1;
      check("t6_err_clear", {31'd0, err}, 32'd0);
      check("t6_idle", {31'd0, busy}, 32'd0);
`endif

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fxp32_dot_ctrl.md
Name: fxp32_dot_ctrl

Overview:
Upstream sequencer for fxp32_mac. It takes a start command with a vector length and a valid/ready stream of 32-bit fixed-point operand pairs. It drives the MAC's operand, accumulate and partial-reset pins to compute one dot product. It captures the MAC's out_c after pipeline drain and presents the result on a valid/ready output.

Parameters:
- DATA_W, 32, operand/result width; matches fxp32_mac.
- LEN_W, 8, width of the vector-length field; max length 2^LEN_W-1.
- MAC_LAT, 2, cycles from operands on mac_a/mac_b to out_c reflecting them (>=1).
- TIMEOUT, 255, idle-input cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; honoured only in IDLE.
- len  in  LEN_W  pair count, sampled with start.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when s_valid&s_ready.
- s_a  in  DATA_W  operand A.
- s_b  in  DATA_W  operand B.
- mac_prstn  out  1  to fxp32_mac prstn; low clears the accumulator.
- mac_acc  out  1  to fxp32_mac acc.
- mac_a  out  DATA_W  to fxp32_mac in_a.
- mac_b  out  DATA_W  to fxp32_mac in_b.
- mac_c  in  DATA_W  from fxp32_mac out_c.
- res_valid  out  1  result valid; held until res_ready.
- res_ready  in  1  result consumer ready.
- res_data  out  DATA_W  dot-product result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values while rst is high: state IDLE, mac_prstn=0, mac_acc=0, mac_a=mac_b=0, s_ready=0, res_valid=0, res_data=0, busy=0, counters 0. Reset asserted mid-operation aborts immediately and discards in-flight data and any pending result.
- All outputs are registered. mac_a/mac_b are zero in every cycle without an accepted pair, so mac_acc may stay high and accumulate zero products.
- IDLE:
  - mac_prstn=1, mac_acc=0, s_ready=0.
  - start with len!=0 -> CLEAR, and rem loads len.
  - start with len==0 -> DONE, with res_data=0 and no MAC activity.
- CLEAR (1 cycle): mac_prstn=0, mac_acc=0 -> RUN.
- RUN:
  - mac_prstn=1, mac_acc=1, s_ready=1.
  - On accept, mac_a/mac_b register s_a/s_b in the next cycle and rem decrements.
  - The accept that takes rem to 0 drops s_ready in the next cycle -> DRAIN.
  - s_valid gaps are legal.
- DRAIN: mac_acc=1, zero operands, counts MAC_LAT+1 cycles, then samples mac_c into res_data -> DONE.
- DONE:
  - res_valid=1, res_data stable, mac_acc=0.
  - res_valid&res_ready -> IDLE; res_valid drops the following cycle.
  - start in this cycle is ignored.
- start in any non-IDLE state is ignored.
- Block throughput is one pair per cycle in RUN. Command latency = 1 (CLEAR) + len (best case) + MAC_LAT+1 (DRAIN) cycles to res_valid.
- No arithmetic is done locally; the result is mac_c verbatim, with wrap/saturation as defined by fxp32_mac.

Optional Feature:
- Macro FXP32_DOT_TIMEOUT_EN.
- When defined:
  - Adds output err (1 bit, reset 0).
  - In RUN, a counter increments on cycles without accept and clears on accept.
  - Reaching TIMEOUT -> DONE with res_data=0, err=1.
  - err clears on the res handshake.
- When undefined: no err port, no counter; RUN waits indefinitely.

Decomposition:
- Shared package fxp32_pkg holds:
  - state encoding (IDLE, CLEAR, RUN, DRAIN, DONE);
  - DATA_W default;
  - Q16.16 format constant FRAC_W=16 shared with the MAC and benches.
- No sub-module needed; one optional counter helper, fxp_cnt, is reusable for rem, drain and timeout.

Test Plan:
- Bench uses a MAC model: Q16.16, accumulates (a*b)>>>16 with 32-bit wrap, MAC_LAT register stages.
- Test 1: start len=2, pairs (0x00010000,0x00020000) and (0x00030000,0x00040000) back-to-back. Expect res_data=0x000E0000, and res_valid on cycle 1+2+MAC_LAT+1 after start.
- Test 2: len=3 with s_valid gaps of 2 cycles, pairs (0x00008000,0x00020000)x3. Expect res_data=0x00030000, and s_ready low after the third accept.
- Test 3: len=0. Expect DONE next cycle, res_data=0, and mac_prstn never low.
- Test 4: res_ready held low 10 cycles; a start pulse issued during DONE is ignored. Expect res_data stable, then IDLE after the handshake.
- Test 5: assert rst mid-RUN after 1 of 4 pairs. Expect all outputs at reset values asynchronously. A new start with len=1, pair (0xFFFF0000,0x00010000), gives res_data=0xFFFF0000 (no residue from the aborted run).
- Test 6 (FXP32_DOT_TIMEOUT_EN, TIMEOUT=8): len=2, one pair then s_valid low. Expect err=1 and res_data=0 after 8 idle cycles.
